fadd_result_checker: RTL and testbench

FADD_RESULT_CHECKER -- requirements
Module: fadd_result_checker

---
 rtl/fadd_result_checker_if.sv | 38 +++
 rtl/fadd_result_checker.sv | 186 ++++++++++++++++++
 tb/tb_fadd_result_checker.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_result_checker_if.sv
// Stimulus and result bundle between an fadd test driver and fadd_result_checker.
// The master side drives issue/operands/results; the slave side returns status and counters.
interface fadd_result_checker_if #(
    parameter int CNT_W = 16
);
    logic                 start;
    logic                 finish;
    logic                 issue;
    logic [31:0]          op1;
    logic [31:0]          op2;
    logic [31:0]          ref_result;
    logic [31:0]          dut_result;

    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     total_cnt;
    logic [CNT_W-1:0]     fail_cnt;
    logic                 first_fail_valid;
    logic [31:0]          first_fail_op1;
    logic [31:0]          first_fail_op2;
    logic [31:0]          first_fail_dut;
    logic [31:0]          first_fail_ref;
    logic [5*CNT_W-1:0]   cat_fail_cnt;

    modport master (
        output start, finish, issue, op1, op2, ref_result, dut_result,
        input  busy, done, total_cnt, fail_cnt, first_fail_valid,
               first_fail_op1, first_fail_op2, first_fail_dut, first_fail_ref,
               cat_fail_cnt
    );

    modport slave (
        input  start, finish, issue, op1, op2, ref_result, dut_result,
        output busy, done, total_cnt, fail_cnt, first_fail_valid,
               first_fail_op1, first_fail_op2, first_fail_dut, first_fail_ref,
               cat_fail_cnt
    );
endinterface

// File: rtl/fadd_result_checker.sv
// Scoreboard for a floating-point adder: compares dut_result against the golden sum LATENCY cycles after issue.
// Define FADD_CHK_CATEGORY_EN to add per-operand-class mismatch counters on cat_fail_cnt.
module fadd_result_checker #(
    parameter int LATENCY = 3,
    parameter int ULP_TOL = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fadd_result_checker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        drain_cnt;
    logic              start_ok;
    logic              accept;

    logic              pipe_vld [LATENCY];
    logic [31:0]       pipe_op1 [LATENCY];
    logic [31:0]       pipe_op2 [LATENCY];
    logic [31:0]       pipe_ref [LATENCY];

    logic              tail_vld;
    logic              tail_fail;

    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  fail_q;
    logic              ff_vld_q;
    logic [31:0]       ff_op1_q;
    logic [31:0]       ff_op2_q;
    logic [31:0]       ff_dut_q;
    logic [31:0]       ff_ref_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Denormals flush to zero, so any two exponent-0 values are equal whatever their sign.
    function automatic logic is_match(input logic [31:0] d, input logic [31:0] r);
        logic [30:0] diff;
        if (d[30:23] == 8'h00 && r[30:23] == 8'h00) return 1'b1;
        diff = (d[30:0] >= r[30:0]) ? d[30:0] - r[30:0] : r[30:0] - d[30:0];
        return (d[31] == r[31]) && (diff <= 31'(ULP_TOL));
    endfunction

    assign start_ok  = bus.start && (state == IDLE || state == DONE);
    assign accept    = bus.issue && (state == RUN);
    assign tail_vld  = pipe_vld[LATENCY-1];
    assign tail_fail = tail_vld && !is_match(bus.dut_result, pipe_ref[LATENCY-1]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.finish) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'(LATENCY - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_vld[i] <= 1'b0;
        end else if (start_ok) begin
            for (int i = 0; i < LATENCY; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether an entry is live.
    always_ff @(posedge clk) begin
        pipe_op1[0] <= bus.op1;
        pipe_op2[0] <= bus.op2;
        pipe_ref[0] <= bus.ref_result;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_op1[i] <= pipe_op1[i-1];
            pipe_op2[i] <= pipe_op2[i-1];
            pipe_ref[i] <= pipe_ref[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || start_ok) begin
            total_q  <= '0;
            fail_q   <= '0;
            ff_vld_q <= 1'b0;
            ff_op1_q <= '0;
            ff_op2_q <= '0;
            ff_dut_q <= '0;
            ff_ref_q <= '0;
        end else if (tail_vld) begin
            total_q <= sat_inc(total_q);
            if (tail_fail) begin
                fail_q <= sat_inc(fail_q);
                if (!ff_vld_q) begin
                    ff_vld_q <= 1'b1;
                    ff_op1_q <= pipe_op1[LATENCY-1];
                    ff_op2_q <= pipe_op2[LATENCY-1];
                    ff_dut_q <= bus.dut_result;
                    ff_ref_q <= pipe_ref[LATENCY-1];
                end
            end
        end
    end

`ifdef FADD_CHK_CATEGORY_EN
    logic [2:0]          pipe_cat [LATENCY];
    logic [CNT_W-1:0]    cat_q [5];
    logic [5*CNT_W-1:0]  cat_flat;

    function automatic logic [2:0] classify(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'h00) return 3'd0;
        if (b[30:23] == 8'h00) return 3'd1;
        if (a[30:23] == 8'hFE) return 3'd2;
        if (b[30:23] == 8'hFE) return 3'd3;
        return 3'd4;
    endfunction

    always_ff @(posedge clk) begin
        pipe_cat[0] <= classify(bus.op1, bus.op2);
        for (int i = 1; i < LATENCY; i++) pipe_cat[i] <= pipe_cat[i-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || start_ok) begin
            for (int k = 0; k < 5; k++) cat_q[k] <= '0;
        end else if (tail_fail) begin
            for (int k = 0; k < 5; k++)
                if (pipe_cat[LATENCY-1] == 3'(k)) cat_q[k] <= sat_inc(cat_q[k]);
        end
    end

    // NOTE: every bit gets a default before the loop so no latch is inferred.
    always_comb begin
        cat_flat = '0;
        for (int k = 0; k < 5; k++) cat_flat[k*CNT_W +: CNT_W] = cat_q[k];
    end

    assign bus.cat_fail_cnt = cat_flat;
`else
    assign bus.cat_fail_cnt = '0;
`endif

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.total_cnt        = total_q;
    assign bus.fail_cnt         = fail_q;
    assign bus.first_fail_valid = ff_vld_q;
    assign bus.first_fail_op1   = ff_op1_q;
    assign bus.first_fail_op2   = ff_op2_q;
    assign bus.first_fail_dut   = ff_dut_q;
    assign bus.first_fail_ref   = ff_ref_q;

endmodule

// File: tb/tb_fadd_result_checker.sv
// Self-checking bench for fadd_result_checker: directed scenarios plus randomized runs against a behavioural model.
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_fadd_result_checker;

    localparam int LAT   = 3;
    localparam int CNT_W = 16;
    localparam int SAT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fadd_result_checker_if #(.CNT_W(CNT_W)) bus ();
    fadd_result_checker_if #(.CNT_W(SAT_W)) sat_bus ();

    fadd_result_checker #(.LATENCY(LAT), .ULP_TOL(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    fadd_result_checker #(.LATENCY(LAT), .ULP_TOL(1), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .reset(reset), .bus(sat_bus)
    );

    assign sat_bus.start      = bus.start;
    assign sat_bus.finish     = bus.finish;
    assign sat_bus.issue      = bus.issue;
    assign sat_bus.op1        = bus.op1;
    assign sat_bus.op2        = bus.op2;
    assign sat_bus.ref_result = bus.ref_result;
    assign sat_bus.dut_result = bus.dut_result;

    int vectors     = 0;
    int miscompares = 0;

    // dut_result for an issue appears LAT cycles later, so results are delayed through a queue.
    logic [31:0] dut_hist [$];

    // Behavioural model of one run.
    int          phase;  // 0 idle/done, 1 run, 2 drain
    int          m_total;
    int          m_fail;
    int          m_cat [5];
    bit          m_ffv;
    logic [31:0] m_ff_op1, m_ff_op2, m_ff_dut, m_ff_ref;

    function automatic bit ref_match(input logic [31:0] d, input logic [31:0] r);
        longint diff;
        if (d[30:23] == 0 && r[30:23] == 0) return 1'b1;
        if (d[31] != r[31]) return 1'b0;
        diff = longint'(d[30:0]) - longint'(r[30:0]);
        if (diff < 0) diff = -diff;
        return diff <= 1;
    endfunction

    function automatic int category(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 0)     return 0;
        if (b[30:23] == 0)     return 1;
        if (a[30:23] == 8'hFE) return 2;
        if (b[30:23] == 8'hFE) return 3;
        return 4;
    endfunction

    function automatic logic [5*CNT_W-1:0] cat_vec(input int c0, c1, c2, c3, c4);
        logic [5*CNT_W-1:0] v;
        v = '0;
`ifdef FADD_CHK_CATEGORY_EN
        v[0*CNT_W +: CNT_W] = CNT_W'(c0);
        v[1*CNT_W +: CNT_W] = CNT_W'(c1);
        v[2*CNT_W +: CNT_W] = CNT_W'(c2);
        v[3*CNT_W +: CNT_W] = CNT_W'(c3);
        v[4*CNT_W +: CNT_W] = CNT_W'(c4);
`endif
        return v;
    endfunction

    task automatic model_clear();
        m_total = 0; m_fail = 0; m_ffv = 0;
        for (int k = 0; k < 5; k++) m_cat[k] = 0;
        m_ff_op1 = 0; m_ff_op2 = 0; m_ff_dut = 0; m_ff_ref = 0;
    endtask

    task automatic model_accept(input logic [31:0] a, b, r, d);
        if (m_total < (1 << CNT_W) - 1) m_total++;
        if (!ref_match(d, r)) begin
            if (m_fail < (1 << CNT_W) - 1) m_fail++;
            m_cat[category(a, b)]++;
            if (!m_ffv) begin
                m_ffv = 1; m_ff_op1 = a; m_ff_op2 = b; m_ff_dut = d; m_ff_ref = r;
            end
        end
    endtask

    // One clock of stimulus: drive at negedge, let the edge happen, return 1 time unit after it.
    task automatic cycle(input bit st, fin, iss, input logic [31:0] a, b, r, d);
        @(negedge clk);
        bus.start = st; bus.finish = fin; bus.issue = iss;
        bus.op1 = a; bus.op2 = b; bus.ref_result = r;
        dut_hist.push_back(d);
        bus.dut_result = dut_hist.pop_front();
        @(posedge clk);
        #1;
        if (phase == 1 && iss) model_accept(a, b, r, d);
        if (phase == 0 && st) begin
            phase = 1;
            model_clear();
        end else if (phase == 1 && fin) begin
            phase = 2;
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_done();
        int got = -1;
        for (int k = 1; k <= 4 * LAT + 4 && got < 0; k++) begin
            idle();
            if (bus.done === 1'b1) got = k;
        end
        vectors++;
        if (got != LAT) begin
            miscompares++;
            $display("FAIL drain_len: done after %0d cycles, expected %0d", got, LAT);
        end
        phase = 0;
    endtask

    task automatic test_reset();
        vectors += 6;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b exp 0", bus.done); end
        if (bus.total_cnt !== '0 || bus.fail_cnt !== '0) begin
            miscompares++; $display("FAIL rst_cnt: total %h fail %h exp 0", bus.total_cnt, bus.fail_cnt);
        end
        if (bus.first_fail_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ffv: got %b exp 0", bus.first_fail_valid); end
        if ({bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref} !== 128'h0) begin
            miscompares++; $display("FAIL rst_ff: got %h %h %h %h exp 0", bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref);
        end
        if (bus.cat_fail_cnt !== '0) begin miscompares++; $display("FAIL rst_cat: got %h exp 0", bus.cat_fail_cnt); end
        @(negedge clk);
        reset = 1'b1;
        idle(); idle();
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_stay_idle: busy %b exp 0", bus.busy); end
    endtask

    task automatic test_basic();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++; $display("FAIL basic_run: busy %b done %b exp 1 0", bus.busy, bus.done);
        end
        cycle(0, 0, 1, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        repeat (LAT - 1) idle();
        vectors++;
        if (bus.total_cnt !== 16'd0) begin miscompares++; $display("FAIL basic_early: total %0d exp 0", bus.total_cnt); end
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        vectors++;
        if (bus.total_cnt !== 16'd1) begin miscompares++; $display("FAIL basic_latency: total %0d exp 1", bus.total_cnt); end
        wait_done();
        vectors++;
        if (bus.busy !== 1'b0 || bus.total_cnt !== 16'd1 || bus.fail_cnt !== 16'd0 || bus.first_fail_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_final: busy %b total %0d fail %0d ffv %b exp 0 1 0 0", bus.busy, bus.total_cnt, bus.fail_cnt, bus.first_fail_valid);
        end
    endtask

    task automatic test_ulp();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h0083AC80, 32'h7E7FFFFF, 32'h7E7FFFFF, 32'h7E800000);
        cycle(0, 1, 1, 32'h0083AC80, 32'h7E7FFFFF, 32'h7E7FFFFF, 32'h7E800001);
        wait_done();
        vectors += 4;
        if (bus.total_cnt !== 16'd2 || bus.fail_cnt !== 16'd1) begin
            miscompares++; $display("FAIL ulp_cnt: total %0d fail %0d exp 2 1", bus.total_cnt, bus.fail_cnt);
        end
        if (bus.first_fail_valid !== 1'b1) begin miscompares++; $display("FAIL ulp_ffv: got %b exp 1", bus.first_fail_valid); end
        if ({bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref} !==
            {32'h0083AC80, 32'h7E7FFFFF, 32'h7E800001, 32'h7E7FFFFF}) begin
            miscompares++;
            $display("FAIL ulp_ff: got %h %h %h %h exp 0083ac80 7e7fffff 7e800001 7e7fffff",
                     bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref);
        end
        if (bus.cat_fail_cnt !== cat_vec(0, 0, 0, 0, 1)) begin
            miscompares++; $display("FAIL ulp_cat: got %h exp %h", bus.cat_fail_cnt, cat_vec(0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_zero();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000001);
        cycle(0, 1, 1, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'hBF800000);
        wait_done();
        vectors += 3;
        if (bus.total_cnt !== 16'd2 || bus.fail_cnt !== 16'd1) begin
            miscompares++; $display("FAIL zero_cnt: total %0d fail %0d exp 2 1", bus.total_cnt, bus.fail_cnt);
        end
        if (bus.first_fail_dut !== 32'hBF800000 || bus.first_fail_ref !== 32'h3F800000) begin
            miscompares++; $display("FAIL zero_ff: dut %h ref %h exp bf800000 3f800000", bus.first_fail_dut, bus.first_fail_ref);
        end
        if (bus.cat_fail_cnt !== cat_vec(1, 0, 0, 0, 0)) begin
            miscompares++; $display("FAIL zero_cat: got %h exp %h", bus.cat_fail_cnt, cat_vec(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40800001);
        cycle(0, 0, 1, 32'h7F000000, 32'h3F800000, 32'h7F000000, 32'h7F000002);
        cycle(0, 0, 1, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F7FFFFF);
        cycle(0, 1, 1, 32'h3F800000, 32'h00000000, 32'h3F800000, 32'hBF800000);
        wait_done();
        vectors += 3;
        if (bus.total_cnt !== 16'd4 || bus.fail_cnt !== 16'd2) begin
            miscompares++; $display("FAIL b2b_cnt: total %0d fail %0d exp 4 2", bus.total_cnt, bus.fail_cnt);
        end
        if ({bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref} !==
            {32'h7F000000, 32'h3F800000, 32'h7F000002, 32'h7F000000}) begin
            miscompares++;
            $display("FAIL b2b_ff: got %h %h %h %h exp 7f000000 3f800000 7f000002 7f000000",
                     bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref);
        end
        if (bus.cat_fail_cnt !== cat_vec(0, 1, 1, 0, 0)) begin
            miscompares++; $display("FAIL b2b_cat: got %h exp %h", bus.cat_fail_cnt, cat_vec(0, 1, 1, 0, 0));
        end
    endtask

    task automatic test_ignored();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000);
        cycle(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (LAT) cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hC0000000);
        vectors++;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL ign_done: got %b exp 1", bus.done); end
        repeat (LAT + 2) cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'hC0000000);
        phase = 0;
        vectors++;
        if (bus.total_cnt !== 16'd1 || bus.fail_cnt !== 16'd0 || bus.done !== 1'b1) begin
            miscompares++; $display("FAIL ign_drain_done: total %0d fail %0d done %b exp 1 0 1", bus.total_cnt, bus.fail_cnt, bus.done);
        end
        // start while running must not clear the run in progress
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000004);
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 1, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000);
        wait_done();
        vectors++;
        if (bus.total_cnt !== 16'd2 || bus.fail_cnt !== 16'd1) begin
            miscompares++; $display("FAIL ign_start: total %0d fail %0d exp 2 1", bus.total_cnt, bus.fail_cnt);
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h50000000);
        cycle(0, 0, 1, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h50000000);
        reset = 1'b0;
        #1;
        phase = 0;
        model_clear();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.total_cnt !== '0 || bus.fail_cnt !== '0 ||
            bus.first_fail_valid !== 1'b0 || bus.cat_fail_cnt !== '0) begin
            miscompares++;
            $display("FAIL midrun_rst: busy %b done %b total %0d fail %0d ffv %b exp all 0",
                     bus.busy, bus.done, bus.total_cnt, bus.fail_cnt, bus.first_fail_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT + 2) idle();
        vectors++;
        if (bus.busy !== 1'b0 || bus.total_cnt !== '0 || bus.fail_cnt !== '0) begin
            miscompares++; $display("FAIL midrun_after: busy %b total %0d fail %0d exp 0 0 0", bus.busy, bus.total_cnt, bus.fail_cnt);
        end
    endtask

    task automatic test_saturate();
        cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++)
            cycle(0, i == 19, 1, 32'h3F800000 + 32'(i), 32'h3F800000, 32'h40000000, 32'h40000010);
        wait_done();
        vectors += 4;
        if (bus.fail_cnt !== 16'd20) begin miscompares++; $display("FAIL sat_wide: fail %0d exp 20", bus.fail_cnt); end
        if (sat_bus.fail_cnt !== 4'hF || sat_bus.total_cnt !== 4'hF) begin
            miscompares++; $display("FAIL sat_cnt: total %h fail %h exp f f", sat_bus.total_cnt, sat_bus.fail_cnt);
        end
        if (sat_bus.first_fail_op1 !== 32'h3F800000) begin
            miscompares++; $display("FAIL sat_ff: op1 %h exp 3f800000", sat_bus.first_fail_op1);
        end
`ifdef FADD_CHK_CATEGORY_EN
        if (sat_bus.cat_fail_cnt !== 20'hF0000) begin
            miscompares++; $display("FAIL sat_cat: got %h exp f0000", sat_bus.cat_fail_cnt);
        end
`else
        if (sat_bus.cat_fail_cnt !== 20'h0) begin
            miscompares++; $display("FAIL sat_cat: got %h exp 0", sat_bus.cat_fail_cnt);
        end
`endif
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'h00;
            1:       e = 8'hFE;
            default: e = 8'($urandom_range(1, 253));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_dut(input logic [31:0] r);
        case ($urandom_range(0, 4))
            0:       return r;
            1:       return {r[31], r[30:0] + 31'($urandom_range(0, 1))};
            2:       return {r[31], r[30:0] - 31'($urandom_range(0, 3))};
            3:       return {~r[31], r[30:0]};
            default: return rnd_fp();
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b, r;
        for (int run = 0; run < 8; run++) begin
            int n = int'($urandom_range(10, 30));
            cycle(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
            for (int i = 0; i < n; i++) begin
                bit iss = ($urandom_range(0, 9) < 7);
                a = rnd_fp(); b = rnd_fp(); r = rnd_fp();
                cycle(0, i == n - 1, iss, a, b, r, rnd_dut(r));
            end
            wait_done();
            vectors += 4;
            if (bus.total_cnt !== CNT_W'(m_total) || bus.fail_cnt !== CNT_W'(m_fail)) begin
                miscompares++;
                $display("FAIL rnd_cnt run %0d: total %0d fail %0d exp %0d %0d", run, bus.total_cnt, bus.fail_cnt, m_total, m_fail);
            end
            if (bus.first_fail_valid !== m_ffv) begin
                miscompares++; $display("FAIL rnd_ffv run %0d: got %b exp %b", run, bus.first_fail_valid, m_ffv);
            end
            if ({bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref} !==
                {m_ff_op1, m_ff_op2, m_ff_dut, m_ff_ref}) begin
                miscompares++;
                $display("FAIL rnd_ff run %0d: got %h %h %h %h exp %h %h %h %h", run,
                         bus.first_fail_op1, bus.first_fail_op2, bus.first_fail_dut, bus.first_fail_ref,
                         m_ff_op1, m_ff_op2, m_ff_dut, m_ff_ref);
            end
            if (bus.cat_fail_cnt !== cat_vec(m_cat[0], m_cat[1], m_cat[2], m_cat[3], m_cat[4])) begin
                miscompares++;
                $display("FAIL rnd_cat run %0d: got %h exp %h", run, bus.cat_fail_cnt,
                         cat_vec(m_cat[0], m_cat[1], m_cat[2], m_cat[3], m_cat[4]));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 0; bus.finish = 0; bus.issue = 0;
        bus.op1 = 0; bus.op2 = 0; bus.ref_result = 0; bus.dut_result = 0;
        for (int i = 0; i < LAT; i++) dut_hist.push_back(32'h0);
        phase = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_ulp();
        test_zero();
        test_back_to_back();
        test_ignored();
        test_reset_midrun();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
